// File: rtl/instr_fetch.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem request/grant/response handshake,
// 2-entry instruction FIFO toward decode, and branch/JAL/JALR redirect handling.
`timescale 1ns/1ps

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // execute-stage redirect
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_jump,
  input  logic        ex_br_taken,
  input  logic        ex_pc_sel,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_alu_r,
  // decode side
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        id_ready,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_RESET,
    S_REQ,
    S_WAIT,
    S_IDLE,
    S_DRAIN,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;

  entry_t      fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_count;
  logic [1:0]  cnt_after;
  entry_t      head;

  logic        redir;
  logic        take_redir;
  logic [31:0] target;
  logic        misalign;
  logic        granted;
  logic        push;
  logic        pop;

  // Redirect decode and target; JALR clears bit 0 of the ALU sum.
  assign redir      = ex_valid & ((ex_branch & ex_br_taken) | ex_jump);
  assign target     = ex_pc_sel ? (ex_alu_r & ~32'h1) : (ex_pc + ex_imm);
  assign misalign   = |target[1:0];
  assign take_redir = redir & (state != S_HALT);

  assign granted    = (state == S_REQ) & imem_gnt;
  assign push       = (state == S_WAIT) & imem_rvalid & ~take_redir;
  assign pop        = (fifo_count != 2'd0) & id_ready;
  assign cnt_after  = fifo_count + {1'b0, push} - {1'b0, pop};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RESET: state_nxt = S_REQ;
      S_REQ:   if (imem_gnt) state_nxt = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_nxt = (cnt_after < 2'd2) ? S_REQ : S_IDLE;
      S_IDLE:  if (cnt_after < 2'd2) state_nxt = S_REQ;
      S_DRAIN: if (imem_rvalid) state_nxt = S_REQ;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase

    // A request granted this cycle, or one still in flight, leaves a stale response to drop.
    if (take_redir) begin
      if (misalign)
        state_nxt = S_HALT;
      else if (((state == S_WAIT || state == S_DRAIN) && !imem_rvalid) ||
               (state == S_REQ && imem_gnt))
        state_nxt = S_DRAIN;
      else
        state_nxt = S_REQ;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register only)
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req  = (state == S_REQ);
    fetch_err = (state == S_HALT);
  end

  assign imem_addr = fetch_pc;

  // ---------------------------------------------------------------------------
  // Fetch PC and the PC of the request in flight
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else begin
      if (granted)
        pend_pc <= fetch_pc;
      // A misaligned target halts fetch; keep imem_addr word-aligned.
      if (take_redir && !misalign)
        fetch_pc <= target;
      else if (granted)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry instruction FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the two entries are reset because the head drives if_pc/if_pc4 even when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int i = 0; i < 2; i++)
        fifo_mem[i] <= '{instr: NOP, pc: RESET_PC};
    end else if (take_redir) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{instr: imem_rdata, pc: pend_pc};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      fifo_count <= cnt_after;
    end
  end

  assign head     = fifo_mem[rd_ptr];
  assign if_valid = (fifo_count != 2'd0);
  assign if_instr = if_valid ? head.instr : NOP;
  assign if_pc    = head.pc;
  assign if_pc4   = head.pc + 32'd4;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_count == 2'd2));

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= 2'd2);

  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    imem_addr[1:0] == 2'b00);

  a_addr_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_REQ && !imem_gnt && !take_redir) |=> $stable(imem_addr));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed redirect/stall/wrap/halt vectors, a latency-
// programmable memory model, and a scoreboard queue drained by an independent monitor.
`timescale 1ns/1ps

module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ex_valid, ex_branch, ex_jump, ex_br_taken, ex_pc_sel;
  logic [31:0] ex_pc, ex_imm, ex_alu_r;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc4;
  logic        id_ready;
  logic        fetch_err;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pops  = 0;
  int   mem_lat = 1;

  // memory model state
  bit          m_pend = 1'b0;
  int          m_cd   = 0;
  logic [31:0] m_addr = 32'h0;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_jump     (ex_jump),
    .ex_br_taken (ex_br_taken),
    .ex_pc_sel   (ex_pc_sel),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_alu_r    (ex_alu_r),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .id_ready    (id_ready),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input bit cond, input int act);
    n_vec++;
    if (!cond) begin
      n_err++;
      $display("FAIL %s: got %0d", name, act);
    end
  endtask

  task automatic sb_flush();
    exp_q.delete();
  endtask

  // Expected sequential stream from start; memory returns addr | 0x13.
  task automatic sb_seq(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{instr: p | 32'h13, pc: p});
      p = p + 32'd4;
    end
  endtask

  // Advance to the middle of the next low phase (inputs driven / outputs sampled here).
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic redirect(input logic br, input logic jmp, input logic sel,
                          input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu);
    ex_valid    = 1'b1;
    ex_branch   = br;
    ex_br_taken = br;
    ex_jump     = jmp;
    ex_pc_sel   = sel;
    ex_pc       = pc;
    ex_imm      = imm;
    ex_alu_r    = alu;
    step(1);
    ex_valid    = 1'b0;
    ex_branch   = 1'b0;
    ex_br_taken = 1'b0;
    ex_jump     = 1'b0;
    ex_pc_sel   = 1'b0;
  endtask

  // Memory: grants immediately, answers mem_lat cycles after the handshake.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (!rst_n) begin
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (m_cd == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = m_addr | 32'h13;
          m_pend      = 1'b0;
        end else begin
          m_cd--;
        end
      end
      imem_gnt = imem_req;
      if (imem_req && rst_n) begin
        m_pend = 1'b1;
        m_addr = imem_addr;
        m_cd   = mem_lat - 1;
      end
    end
  end

  // Monitor: every accepted instruction is compared with the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && if_valid && id_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got pc %h instr %h expected none", if_pc, if_instr);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc",    if_pc,    e.pc);
          check("sb_instr", if_instr, e.instr);
          check("sb_pc4",   if_pc4,   e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    #100000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int p0;
    rst_n = 1'b0; id_ready = 1'b0;
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_br_taken = 1'b0; ex_pc_sel = 1'b0;
    ex_pc = 32'h0; ex_imm = 32'h0; ex_alu_r = 32'h0;

    // Reset values
    step(1);
    check("rst_req",   {31'b0, imem_req},  32'd0);
    check("rst_addr",  imem_addr,          32'h0);
    check("rst_valid", {31'b0, if_valid},  32'd0);
    check("rst_instr", if_instr,           NOP);
    check("rst_pc",    if_pc,              32'h0);
    check("rst_pc4",   if_pc4,             32'h4);
    check("rst_err",   {31'b0, fetch_err}, 32'd0);
    step(2);
    check("rst_req_hold", {31'b0, imem_req}, 32'd0);

    // Reset then run with 1-cycle memory
    sb_seq(32'h0, 40);
    id_ready = 1'b1;
    rst_n    = 1'b1;
    step(1);
    check("first_req",  {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr,         32'h0);
    step(9);
    p0 = pops;
    step(20);
    check("throughput", pops - p0, 10);

    // Decode stall: FIFO fills, requests stop, order kept on release
    id_ready = 1'b0;
    step(10);
    check("stall_req",   {31'b0, imem_req}, 32'd0);
    check("stall_valid", {31'b0, if_valid}, 32'd1);
    id_ready = 1'b1;
    p0 = pops;
    step(8);
    id_ready = 1'b0;
    step(8);
    check_true("stall_release_pops", (pops - p0) >= 3, pops - p0);

    // Taken branch 0x100 + (-16) = 0xF0
    sb_flush();
    sb_seq(32'hF0, 30);
    redirect(1'b1, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFF0, 32'h0);
    check("br_req",    {31'b0, imem_req}, 32'd1);
    check("br_addr",   imem_addr,         32'hF0);
    check("br_flush",  {31'b0, if_valid}, 32'd0);
    step(1);
    check("br_n2_valid", {31'b0, if_valid}, 32'd0);
    step(1);
    check("br_n3_valid", {31'b0, if_valid}, 32'd1);
    check("br_n3_pc",    if_pc,             32'hF0);
    check("br_n3_instr", if_instr,          32'hF3);
    id_ready = 1'b1;
    p0 = pops;
    step(10);
    id_ready = 1'b0;
    step(8);
    check_true("br_pops", (pops - p0) >= 3, pops - p0);

    // PC wrap: JAL 0x10 + (-20) = 0xFFFFFFFC, next fetch at 0
    sb_flush();
    sb_seq(32'hFFFF_FFFC, 30);
    redirect(1'b0, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFEC, 32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1);
    check("wrap_next_addr", imem_addr, 32'h0);
    step(1);
    check("wrap_pc",  if_pc,  32'hFFFF_FFFC);
    check("wrap_pc4", if_pc4, 32'h0);
    id_ready = 1'b1;
    p0 = pops;
    step(10);
    id_ready = 1'b0;
    step(8);
    check_true("wrap_pops", (pops - p0) >= 3, pops - p0);

    // JALR 0x201 while a 3-cycle response is outstanding: target 0x200, stale dropped
    mem_lat = 3;
    step(1);
    sb_flush();
    redirect(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0);
    check("drain_pre_addr", imem_addr, 32'h300);
    step(1);
    redirect(1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 32'h201);
    check("drain_req",   {31'b0, imem_req}, 32'd0);
    check("drain_addr",  imem_addr,         32'h200);
    check("drain_valid", {31'b0, if_valid}, 32'd0);
    sb_seq(32'h200, 30);
    step(2);
    check("drain_req2",   {31'b0, imem_req}, 32'd1);
    check("drain_addr2",  imem_addr,         32'h200);
    check("drain_valid2", {31'b0, if_valid}, 32'd0);
    id_ready = 1'b1;
    p0 = pops;
    step(24);
    id_ready = 1'b0;
    step(12);
    check_true("drain_pops", (pops - p0) >= 3, pops - p0);

    // JALR 0x203 while outstanding: target 0x202 is misaligned -> HALT
    sb_flush();
    redirect(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0);
    step(1);
    redirect(1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 32'h203);
    for (int i = 0; i < 5; i++) begin
      check("halt_err",   {31'b0, fetch_err}, 32'd1);
      check("halt_req",   {31'b0, imem_req},  32'd0);
      check("halt_valid", {31'b0, if_valid},  32'd0);
      step(1);
    end
    redirect(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0);
    check("halt_ignore_err", {31'b0, fetch_err}, 32'd1);
    check("halt_ignore_req", {31'b0, imem_req},  32'd0);

    // Reset pulse clears HALT
    rst_n   = 1'b0;
    mem_lat = 1;
    step(1);
    check("rst2_err",  {31'b0, fetch_err}, 32'd0);
    check("rst2_req",  {31'b0, imem_req},  32'd0);
    check("rst2_addr", imem_addr,          32'h0);
    rst_n = 1'b1;
    step(1);
    check("rst2_run_req", {31'b0, imem_req}, 32'd1);
    step(6);
    check("rst2_fill_valid", {31'b0, if_valid}, 32'd1);
    check("rst2_fill_pc",    if_pc,             32'h0);
    check("rst2_fill_instr", if_instr,          32'h13);

    // JAL to 0x102: misaligned, sticky trap until reset
    redirect(1'b0, 1'b1, 1'b0, 32'h100, 32'h2, 32'h0);
    check("jal_instr", if_instr, NOP);
    for (int i = 0; i < 4; i++) begin
      check("jal_err",   {31'b0, fetch_err}, 32'd1);
      check("jal_req",   {31'b0, imem_req},  32'd0);
      check("jal_valid", {31'b0, if_valid},  32'd0);
      step(1);
    end
    rst_n = 1'b0;
    step(1);
    check("rst3_err", {31'b0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    step(2);
    check("rst3_req_after", {31'b0, imem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the RV32I core. Holds the PC, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions in a 2-entry FIFO. Presents instructions to the decoder/`Control_unit`. Takes branch, JAL and JALR redirects from the execute stage, whose inputs come from the `Branch`/`pc_sel` controls, the branch-condition output and the ALU result.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0013, value driven on `if_instr` when no valid instruction

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  word-aligned fetch address
- `imem_gnt`  in  1  request accepted this cycle (`imem_req & imem_gnt` = handshake)
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  32  fetched instruction
- `ex_valid`  in  1  execute-stage instruction valid
- `ex_branch`  in  1  conditional branch in execute
- `ex_jump`  in  1  JAL/JALR in execute
- `ex_br_taken`  in  1  branch condition result
- `ex_pc_sel`  in  1  1 = JALR target from ALU
- `ex_pc`  in  32  PC of the execute instruction
- `ex_imm`  in  32  sign-extended branch/JAL offset
- `ex_alu_r`  in  32  ALU result (JALR base+offset)
- `if_valid`  out  1  instruction available to decode
- `if_instr`  out  32  instruction
- `if_pc`  out  32  its PC
- `if_pc4`  out  32  `if_pc + 4` (link value)
- `id_ready`  in  1  decode accepts; pop on `if_valid & id_ready`
- `fetch_err`  out  1  sticky misaligned-target trap

## Operation
- Redirect: `redir = ex_valid & ((ex_branch & ex_br_taken) | ex_jump)`.
- Target: `ex_pc_sel ? {ex_alu_r[31:1],1'b0} : ex_pc + ex_imm`. The addition is a 32-bit modulo sum; carry is dropped and wrap-around is legal.
- `fetch_pc` register. After each granted request it advances by 4 (modulo 2^32). It loads the target on `redir`.
- Only one request may be outstanding. A request is issued only when `fifo_count + outstanding < 2`.
- FSM states:
  - RESET: active while `rst_n=0`; goes to REQ on the first cycle with `rst_n=1`.
  - REQ: assert `imem_req`. On `gnt`, go to WAIT. Hold `imem_addr` stable until `gnt`, except on `redir`.
  - WAIT: on `rvalid`, push `{rdata, pc}` into the FIFO. Then go to REQ if the space rule allows; otherwise go to IDLE.
  - IDLE: no request. Go to REQ when a FIFO slot frees.
  - DRAIN: discard the next `rvalid`, then go to REQ.
  - HALT: `fetch_err=1`, no requests; leave only on reset.
- `redir` in any non-HALT state:
  - FIFO cleared; `fetch_pc` loaded with the target.
  - If a response is outstanding and not returning this cycle, go to DRAIN; otherwise go to REQ.
  - A same-cycle `rvalid` is discarded.
  - A same-cycle `gnt` counts as outstanding, so the next state is DRAIN.
- Target with `[1:0] != 0`: enter HALT, clear the FIFO, set `fetch_err`.
- FIFO: 2 entries, circular pointers.
  - Push and pop in the same cycle are allowed when full; the count stays unchanged.
  - A push never occurs when the count is 2 (guaranteed by the issue rule).
  - `if_*` are driven from the head entry; `if_instr = NOP` when empty.

## Timing
- Reset values: `imem_req=0`, `imem_addr=RESET_PC`, `if_valid=0`, `if_instr=NOP`, `if_pc=RESET_PC`, `if_pc4=RESET_PC+4`, `fetch_err=0`, FIFO empty, no outstanding request.
- A reset asserted mid-operation wins over everything: state returns to the reset values on that edge, and any in-flight response is ignored.
- `imem_req` first rises in the cycle after `rst_n` deasserts.
- All outputs are registered or driven from FIFO registers. No combinational path from `ex_*` or `imem_*` to outputs.
- Response is pushed at the `rvalid` edge; `if_valid` is high the next cycle.
- Back-to-back fetch with 1-cycle memory (`gnt` immediate, `rvalid` the following cycle): one instruction every 2 cycles.
- Redirect at edge N: `if_valid=0` after N; `imem_addr=target` with `imem_req=1` in cycle N+1. With 1-cycle memory, `if_valid` returns at N+3.

## Test plan
- Reset then run: `RESET_PC=0`, 1-cycle memory returning `addr|0x13`. Expect `if_pc` sequence 0, 4, 8; `if_pc4` = `if_pc + 4`; `imem_req` low during reset.
- Decode stall: `id_ready=0` for 10 cycles. Expect the FIFO to fill to 2, requests to stop, no entries lost or duplicated, and the order preserved after release.
- Taken branch: `ex_pc=0x100`, `ex_imm=0xFFFFFFF0`. Expect the next `imem_addr=0xF0`, FIFO flushed, and the first new `if_pc=0xF0`.
- Redirect while response outstanding: JALR with `ex_alu_r=0x203`, memory latency 3. Expect the stale response dropped (DRAIN) and the first `if_pc=0x202`... expect HALT instead, because bit 1 is set. Repeat with `0x201`: expect target `0x200` and the stale response dropped.
- Misaligned target: JAL target `0x102`. Expect `fetch_err=1` sticky, `imem_req=0`, `if_valid=0` until `rst_n` is pulsed.
- PC wrap: start at `0xFFFFFFFC`. Expect the next fetch at `0x00000000` and `if_pc4=0` for the wrapping instruction.
